// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder built around a single full_adder cell.
// Operands are captured on a start handshake and added LSB first, one bit
// pair per clock. The cell's carry-out is registered between bits. After
// WIDTH shift cycles the sum and final carry-out are published, and done
// pulses for one cycle.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ ci;
    assign cout = (a & b) | (ci & (a ^ b));

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             ci_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_s;
    logic             w_fa_cout;
    logic             w_accept;
    logic             w_shifting;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    // The one adder cell: current LSBs of both operands plus the carried bit.
    full_adder u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .ci   (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_shifting = (r_state == S_SHIFT);
    assign w_last     = w_shifting && (r_cnt == CNT_LAST);

    // New sum bits enter at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
    assign w_sum_next = {w_fa_s, r_s_sh[WIDTH-1:1]};

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start is only looked at in IDLE, DONE always lasts one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next_state = S_SHIFT;
            S_SHIFT: if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Output decode: busy and done are pure functions of the state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: load operands on accept, shift one bit pair per SHIFT cycle,
    // publish the result only on the final shift so an aborted run leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= ci_in;
            r_cnt   <= '0;
        end else if (w_shifting) begin
            r_s_sh  <= w_sum_next;
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_sum  <= w_sum_next;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2.
// Expected results come from plain integer addition of the operands.

module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8;
    logic [7:0] a8, b8;
    logic       ci8;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2;
    logic [1:0] a2, b2;
    logic       ci2;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

    int errors = 0;
    int checks = 0;

    logic [7:0] prev8_sum  = '0;
    logic       prev8_cout = 1'b0;
    logic [1:0] prev2_sum  = '0;
    logic       prev2_cout = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a_in  (a8),
        .b_in  (b8),
        .ci_in (ci8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a_in  (a2),
        .b_in  (b2),
        .ci_in (ci2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
    );

    // Advance past one rising edge; values are then stable until the next edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one request into the 8-bit instance and pass the accepting edge E0.
    task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
        a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    // Walk edges E1..E9 of an 8-bit run, checking handshake, held result and final result.
    task automatic wait8_done(input logic [7:0] a, input logic [7:0] b, input logic ci, input string name);
        logic [8:0] full;
        full = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if ({busy8, done8} !== ((k <= 8) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL %s busy/done at E%0d: got %b expected %b", name, k, {busy8, done8},
                         (k <= 8) ? 2'b10 : 2'b01);
            end
            if (k <= 8) begin
                checks++;
                if ({cout8, sum8} !== {prev8_cout, prev8_sum}) begin
                    errors++;
                    $display("FAIL %s hold at E%0d: got %h expected %h", name, k, {cout8, sum8},
                             {prev8_cout, prev8_sum});
                end
            end else begin
                checks++;
                if ({cout8, sum8} !== full) begin
                    errors++;
                    $display("FAIL %s result: got %h expected %h", name, {cout8, sum8}, full);
                end
            end
            tick();
        end
        prev8_sum  = full[7:0];
        prev8_cout = full[8];
        checks++;
        if ({busy8, done8, cout8, sum8} !== {2'b00, full}) begin
            errors++;
            $display("FAIL %s after done at E10: got %h expected %h", name,
                     {busy8, done8, cout8, sum8}, {2'b00, full});
        end
    endtask

    // One complete operation on the 2-bit instance.
    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic ci);
        logic [2:0] full;
        full = {1'b0, a} + {1'b0, b} + {2'd0, ci};
        a2 = a; b2 = b; ci2 = ci; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        a2 = ~a; b2 = ~b; ci2 = ~ci;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({busy2, done2} !== ((k <= 2) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL w2 busy/done at E%0d: got %b expected %b", k, {busy2, done2},
                         (k <= 2) ? 2'b10 : 2'b01);
            end
            if (k <= 2) begin
                checks++;
                if ({cout2, sum2} !== {prev2_cout, prev2_sum}) begin
                    errors++;
                    $display("FAIL w2 hold at E%0d: got %h expected %h", k, {cout2, sum2},
                             {prev2_cout, prev2_sum});
                end
            end else begin
                checks++;
                if ({cout2, sum2} !== full) begin
                    errors++;
                    $display("FAIL w2 result a=%h b=%h ci=%b: got %h expected %h", a, b, ci,
                             {cout2, sum2}, full);
                end
            end
            tick();
        end
        prev2_sum  = full[1:0];
        prev2_cout = full[2];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; ci2 = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            errors++;
            $display("FAIL reset w8: got %h expected 0", {busy8, done8, cout8, sum8});
        end
        checks++;
        if ({busy2, done2, cout2, sum2} !== 5'd0) begin
            errors++;
            $display("FAIL reset w2: got %h expected 0", {busy2, done2, cout2, sum2});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({busy8, done8} !== 2'b00) begin
            errors++;
            $display("FAIL idle after reset: got %b expected 00", {busy8, done8});
        end
    endtask

    task automatic test_directed;
        start8_op(8'h00, 8'h00, 1'b0); wait8_done(8'h00, 8'h00, 1'b0, "zero");
        start8_op(8'hFF, 8'h01, 1'b0); wait8_done(8'hFF, 8'h01, 1'b0, "ripple");
        start8_op(8'hA5, 8'h5A, 1'b1); wait8_done(8'hA5, 8'h5A, 1'b1, "wrap_ci");
        start8_op(8'h3C, 8'h0F, 1'b0); wait8_done(8'h3C, 8'h0F, 1'b0, "mixed");
    endtask

    task automatic test_start_during_busy;
        a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'h11; b8 = 8'h22;
        wait8_done(8'h01, 8'h01, 1'b0, "busy_first");
        tick();
        start8 = 1'b0;
        wait8_done(8'h11, 8'h22, 1'b0, "busy_second");
    endtask

    task automatic test_reset_mid_op;
        start8_op(8'hFF, 8'hFF, 1'b0);
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            errors++;
            $display("FAIL async reset mid-op: got %h expected 0", {busy8, done8, cout8, sum8});
        end
        tick();
        rst = 1'b0;
        prev8_sum = '0; prev8_cout = 1'b0;
        prev2_sum = '0; prev2_cout = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({busy8, done8, cout8, sum8} !== 11'd0) begin
                errors++;
                $display("FAIL no pulse after abort cycle %0d: got %h expected 0", k,
                         {busy8, done8, cout8, sum8});
            end
            tick();
        end
        start8_op(8'h80, 8'h80, 1'b0); wait8_done(8'h80, 8'h80, 1'b0, "after_reset");
    endtask

    task automatic test_random8;
        logic [7:0] a, b;
        logic       ci;
        for (int n = 0; n < 1000; n++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom);
            start8_op(a, b, ci);
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            wait8_done(a, b, ci, "random8");
        end
    endtask

    task automatic test_random2;
        for (int n = 0; n < 1000; n++) begin
            op2(2'($urandom), 2'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_start_during_busy();
        test_reset_mid_op();
        test_random8();
        test_random2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that sits directly upstream of, and wraps, the team's `full_adder` cell. It accepts two WIDTH-bit operands plus a carry-in through a start handshake. It then feeds the `full_adder` cell one bit pair per clock, LSB first, and registers the cell's carry-out between bits. After WIDTH cycles it presents the full sum and the final carry-out with a one-cycle done pulse.

## Interface
- WIDTH, default 8: operand width in bits; legal range is WIDTH ≥ 2.
- clk  in  1  the single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request a new addition; sampled only in IDLE.
- a_in  in  WIDTH  operand A; captured on the accepting edge.
- b_in  in  WIDTH  operand B; captured on the accepting edge.
- ci_in  in  1  carry-in; captured on the accepting edge.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; high while in DONE.
- sum  out  WIDTH  result register, a_in + b_in + ci_in mod 2^WIDTH.
- cout  out  1  final carry-out, bit WIDTH of the full sum.

## Operation
- Instantiates one `full_adder` cell (ports a, b, ci, s, cout). It is driven by a_sh[0], b_sh[0] and the carry register.
- Internal state:
  - a_sh and b_sh: WIDTH-bit operand shift registers.
  - carry: 1-bit carry register.
  - s_sh: WIDTH-bit sum shift register.
  - cnt: bit counter, $clog2(WIDTH) bits.
  - state: the current FSM state.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - When start=1 at an edge, load a_sh←a_in, b_sh←b_in, carry←ci_in, cnt←0.
  - Go to SHIFT.
  - start=0: stay.
- SHIFT, on each edge:
  - s_sh←{cell.s, s_sh[WIDTH-1:1]}.
  - a_sh←a_sh>>1 and b_sh←b_sh>>1, zero-filled.
  - carry←cell.cout; cnt←cnt+1.
- SHIFT, final edge (cnt==WIDTH-1):
  - Additionally load sum←{cell.s, s_sh[WIDTH-1:1]} and cout←cell.cout.
  - Go to DONE.
- DONE: lasts one cycle, then the next edge returns to IDLE unconditionally.
- start is ignored in SHIFT and DONE; no queuing. a_in, b_in and ci_in are don't-care outside the accepting edge.
- sum and cout change only on the final SHIFT edge. They hold their value through DONE and IDLE until the next operation completes.
- Reset (any time, including mid-SHIFT):
  - Immediately returns to IDLE and clears all registers.
  - Outputs go to busy=0, done=0, sum=0, cout=0.
  - An aborted operation produces no done pulse and no update to sum or cout.
- Arithmetic: {cout,sum} = a_in + b_in + ci_in, exact as a (WIDTH+1)-bit result; no overflow flagging.

## Timing
- Edge E0 is the accepting edge (IDLE with start=1). busy goes high after E0.
- Shift edges are E1…E_WIDTH.
- sum and cout are valid after E_WIDTH, at the same time busy falls and done rises.
- done is high for exactly one cycle and is sampled high at edge E_WIDTH+1.
- The earliest next accepting edge is E_WIDTH+2, which gives a throughput of one operation per WIDTH+2 cycles.
- Latency, start edge to done sampled, is WIDTH+1 edges: 9 for WIDTH=8.
- The carry path is one full_adder cell plus one register, i.e. one cell delay per cycle.
- Reset is asynchronous on assertion. Release must be synchronous to clk; the upstream reset synchroniser provides this.

## Test plan
- WIDTH=8, a=0x00, b=0x00, ci=0 -> sum=0x00, cout=0; done sampled high exactly at E9 and low at E8 and E10; busy high E1–E8.
- Carry ripple and wrap:
  - a=0xFF, b=0x01, ci=0 -> sum=0x00, cout=1.
  - a=0xA5, b=0x5A, ci=1 -> sum=0x00, cout=1.
- Mixed operands: a=0x3C, b=0x0F, ci=0 -> sum=0x4B, cout=0; the previous result holds until E8 of this run.
- Start during busy: start=1 with a=0x11, b=0x22 held through E0–E10 of an a=0x01, b=0x01 run.
  - The first result must be 0x02.
  - A second operation is accepted only at E10, from IDLE, and yields 0x33.
- Reset mid-op: assert rst at E4 of an a=0xFF, b=0xFF run.
  - Outputs go to 0 immediately, with no done pulse.
  - After release, a new a=0x80, b=0x80, ci=0 run yields sum=0x00, cout=1.
- Randomised check: 1000 random {a, b, ci} with WIDTH=8 and WIDTH=2, compared against the behavioural a+b+ci model.
